// File: rtl/lif_core_pkg.sv
// Shared types and saturating arithmetic for the LIF core.
// All datapath values are signed DSIZE fixed point; nothing wraps.
package lif_core_pkg;

  localparam int DATA_INT  = 8;
  localparam int DATA_FRAC = 8;
  localparam int DSIZE     = DATA_INT + DATA_FRAC;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    ACC,
    CMP,
    DONE
  } lifState_t;

  typedef enum logic [1:0] {
    CFG_WEIGHT = 2'd0,
    CFG_THRESH = 2'd1,
    CFG_BIAS   = 2'd2,
    CFG_RSTPOT = 2'd3
  } cfgSel_t;

  // Two guard bits are enough for the sum of three DSIZE operands.
  localparam logic signed [DSIZE+1:0] WIDE_MAX = {3'b000, {(DSIZE-1){1'b1}}};
  localparam logic signed [DSIZE+1:0] WIDE_MIN = {3'b111, {(DSIZE-1){1'b0}}};

  function automatic logic signed [DSIZE+1:0] sx(input logic signed [DSIZE-1:0] x);
    return $signed({{2{x[DSIZE-1]}}, x});
  endfunction

  function automatic logic signed [DSIZE-1:0] sat_clip(input logic signed [DSIZE+1:0] x);
    if (x > WIDE_MAX) return WIDE_MAX[DSIZE-1:0];
    else if (x < WIDE_MIN) return WIDE_MIN[DSIZE-1:0];
    else return x[DSIZE-1:0];
  endfunction

  function automatic logic signed [DSIZE-1:0] sat_add(input logic signed [DSIZE-1:0] a,
                                                      input logic signed [DSIZE-1:0] b);
    return sat_clip(sx(a) + sx(b));
  endfunction

  function automatic logic signed [DSIZE-1:0] sat_sub(input logic signed [DSIZE-1:0] a,
                                                      input logic signed [DSIZE-1:0] b);
    return sat_clip(sx(a) - sx(b));
  endfunction

  function automatic logic signed [DSIZE-1:0] sat_add3(input logic signed [DSIZE-1:0] a,
                                                       input logic signed [DSIZE-1:0] b,
                                                       input logic signed [DSIZE-1:0] c);
    return sat_clip(sx(a) + sx(b) + sx(c));
  endfunction

endpackage

// File: rtl/lif_core_spike_out_fifo.sv
// Synchronous output FIFO for AER spike packets with valid/ready head.
// Depth must be a power of two (>= 2) so the pointers wrap for free.
module spike_out_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] pushData,
  input  logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] head,
  output logic             full
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wrPtr;
  logic [PTR_W-1:0] rdPtr;
  logic [CNT_W-1:0] count;
  logic             doPush;
  logic             doPop;

  // full comes straight from the count register, so a same-cycle pop never
  // opens a slot for a push
  assign valid  = (count != '0);
  assign full   = (count == CNT_W'(DEPTH));
  assign doPush = push && !full;
  assign doPop  = valid && ready;
  assign head   = valid ? mem[rdPtr] : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (doPush) begin
        mem[wrPtr] <= pushData;
        wrPtr      <= wrPtr + 1'b1;
      end
      if (doPop) rdPtr <= rdPtr + 1'b1;
      case ({doPush, doPop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/lif_core.sv
// Time-multiplexed leaky-integrate-and-fire core: one neuron-axon product per
// cycle, one threshold/leak decision per neuron, spikes out as AER packets.
//
// state | meaning
// IDLE  | waiting for start_i; config writes accepted
// LOAD  | spike vector latched, counters cleared
// ACC   | accumulate weight of axon a into neuron n
// CMP   | threshold, fire or leak neuron n; holds while FIFO full on a spike
// DONE  | one-cycle step-complete pulse
module lif_core
  import lif_core_pkg::*;
#(
  parameter int          NUM_NURNS           = 4,
  parameter int          NUM_AXONS           = 4,
  parameter int          NURN_CNT_BIT_WIDTH  = 2,
  parameter int          AXON_CNT_BIT_WIDTH  = 2,
  parameter int          DATA_BIT_WIDTH_INT  = 8,
  parameter int          DATA_BIT_WIDTH_FRAC = 8,
  parameter int          AER_BIT_WIDTH       = 32,
  parameter logic [31:0] AER_BASE            = 32'h0000_0100,
  parameter int          LEAK_SHIFT          = 4,
  parameter int          OUT_FIFO_DEPTH      = 4
) (
  input  logic                                             clk_i,
  input  logic                                             rst_i,
  input  logic                                             start_i,
  input  logic [NUM_AXONS-1:0]                             inSpike_i,
  input  logic                                             cfgWrEn_i,
  input  logic [1:0]                                       cfgSel_i,
  input  logic [NURN_CNT_BIT_WIDTH+AXON_CNT_BIT_WIDTH-1:0] cfgAddr_i,
  input  logic [DATA_BIT_WIDTH_INT+DATA_BIT_WIDTH_FRAC-1:0] cfgData_i,
  output logic                                             spkValid_o,
  input  logic                                             spkReady_i,
  output logic [AER_BIT_WIDTH-1:0]                         SpikePacket_o,
  output logic                                             busy_o,
  output logic                                             stepDone_o,
  output logic                                             overrun_o,
  output logic                                             cfgErr_o
);

  localparam int NUM_CELLS = NUM_NURNS * NUM_AXONS;
  localparam int ADDR_W    = NURN_CNT_BIT_WIDTH + AXON_CNT_BIT_WIDTH;

  logic signed [DSIZE-1:0] weightMem [NUM_CELLS];
  logic signed [DSIZE-1:0] thMem     [NUM_NURNS];
  logic signed [DSIZE-1:0] biasMem   [NUM_NURNS];
  logic signed [DSIZE-1:0] rstPotMem [NUM_NURNS];
  logic signed [DSIZE-1:0] potMem    [NUM_NURNS];

  lifState_t                     state, stateNxt;
  logic [NURN_CNT_BIT_WIDTH-1:0] n, nNxt;
  logic [AXON_CNT_BIT_WIDTH-1:0] a, aNxt;
  logic signed [DSIZE-1:0]       acc, accNxt;
  logic [NUM_AXONS-1:0]          spkBuf;

  logic signed [DSIZE-1:0]  vSum;
  logic signed [DSIZE-1:0]  leaked;
  logic                     fire;
  logic                     potWe;
  logic signed [DSIZE-1:0]  potWrData;
  logic                     fifoPush;
  logic                     fifoFull;
  logic [AER_BIT_WIDTH-1:0] pushPkt;
  logic [NURN_CNT_BIT_WIDTH-1:0] cfgNurn;
  logic                     idle;

  assign idle       = (state == IDLE);
  assign busy_o     = !idle;
  assign stepDone_o = (state == DONE);
  assign cfgNurn    = cfgAddr_i[ADDR_W-1 -: NURN_CNT_BIT_WIDTH];
  assign pushPkt    = AER_BASE[AER_BIT_WIDTH-1:0]
                    | {{(AER_BIT_WIDTH-NURN_CNT_BIT_WIDTH){1'b0}}, n};

  assign vSum   = sat_add3(potMem[n], acc, biasMem[n]);
  assign fire   = (vSum >= thMem[n]);
  assign leaked = (LEAK_SHIFT == 0) ? vSum : sat_sub(vSum, vSum >>> LEAK_SHIFT);

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= IDLE;
    else       state <= stateNxt;
  end

  always_comb begin
    stateNxt  = state;
    nNxt      = n;
    aNxt      = a;
    accNxt    = acc;
    potWe     = 1'b0;
    potWrData = '0;
    fifoPush  = 1'b0;
    case (state)
      IDLE: if (start_i) stateNxt = LOAD;
      LOAD: begin
        nNxt     = '0;
        aNxt     = '0;
        accNxt   = '0;
        stateNxt = ACC;
      end
      ACC: begin
        if (spkBuf[a]) accNxt = sat_add(acc, weightMem[{n, a}]);
        if (a == AXON_CNT_BIT_WIDTH'(NUM_AXONS - 1)) stateNxt = CMP;
        else                                           aNxt     = a + 1'b1;
      end
      CMP: begin
        // a spike with no FIFO room holds the neuron untouched until a slot frees
        if (!(fire && fifoFull)) begin
          fifoPush  = fire;
          potWe     = 1'b1;
          potWrData = fire ? rstPotMem[n] : leaked;
          aNxt      = '0;
          accNxt    = '0;
          if (n == NURN_CNT_BIT_WIDTH'(NUM_NURNS - 1)) begin
            stateNxt = DONE;
          end else begin
            nNxt     = n + 1'b1;
            stateNxt = ACC;
          end
        end
      end
      DONE:    stateNxt = IDLE;
      default: stateNxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      n         <= '0;
      a         <= '0;
      acc       <= '0;
      spkBuf    <= '0;
      overrun_o <= 1'b0;
      cfgErr_o  <= 1'b0;
    end else begin
      n         <= nNxt;
      a         <= aNxt;
      acc       <= accNxt;
      overrun_o <= start_i && !idle;
      cfgErr_o  <= cfgWrEn_i && !idle;
      if (idle && start_i) spkBuf <= inSpike_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_CELLS; i++) weightMem[i] <= '0;
      for (int i = 0; i < NUM_NURNS; i++) begin
        thMem[i]     <= '0;
        biasMem[i]   <= '0;
        rstPotMem[i] <= '0;
        potMem[i]    <= '0;
      end
    end else begin
      if (potWe) potMem[n] <= potWrData;
      if (idle && cfgWrEn_i) begin
        case (cfgSel_t'(cfgSel_i))
          CFG_WEIGHT: weightMem[cfgAddr_i] <= cfgData_i;
          CFG_THRESH: thMem[cfgNurn]       <= cfgData_i;
          CFG_BIAS:   biasMem[cfgNurn]     <= cfgData_i;
          CFG_RSTPOT: rstPotMem[cfgNurn]   <= cfgData_i;
          default:    ;
        endcase
      end
    end
  end

  spike_out_fifo #(
    .WIDTH (AER_BIT_WIDTH),
    .DEPTH (OUT_FIFO_DEPTH)
  ) uOutFifo (
    .clk      (clk_i),
    .rst      (rst_i),
    .push     (fifoPush),
    .pushData (pushPkt),
    .ready    (spkReady_i),
    .valid    (spkValid_o),
    .head     (SpikePacket_o),
    .full     (fifoFull)
  );

endmodule

// File: tb/tb_lif_core.sv
// Directed bench for lif_core (leak shift 4, two-entry output FIFO) with
// hand-computed potentials, packets and step latencies.
module tb_lif_core;
  import lif_core_pkg::*;

  localparam int STEP_BUDGET = 80;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        start_i = 1'b0;
  logic [3:0]  inSpike_i = '0;
  logic        cfgWrEn_i = 1'b0;
  logic [1:0]  cfgSel_i = '0;
  logic [3:0]  cfgAddr_i = '0;
  logic [15:0] cfgData_i = '0;
  logic        spkValid_o;
  logic        spkReady_i = 1'b0;
  logic [31:0] SpikePacket_o;
  logic        busy_o, stepDone_o, overrun_o, cfgErr_o;

  int total = 0;
  int bad   = 0;

  lif_core #(
    .LEAK_SHIFT     (4),
    .OUT_FIFO_DEPTH (2)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .start_i       (start_i),
    .inSpike_i     (inSpike_i),
    .cfgWrEn_i     (cfgWrEn_i),
    .cfgSel_i      (cfgSel_i),
    .cfgAddr_i     (cfgAddr_i),
    .cfgData_i     (cfgData_i),
    .spkValid_o    (spkValid_o),
    .spkReady_i    (spkReady_i),
    .SpikePacket_o (SpikePacket_o),
    .busy_o        (busy_o),
    .stepDone_o    (stepDone_o),
    .overrun_o     (overrun_o),
    .cfgErr_o      (cfgErr_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] u16(input logic [15:0] x);
    return {16'h0, x};
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic cfgWrite(input logic [1:0] sel, input logic [3:0] addr, input logic [15:0] data);
    cfgWrEn_i = 1'b1;
    cfgSel_i  = sel;
    cfgAddr_i = addr;
    cfgData_i = data;
    tick();
    cfgWrEn_i = 1'b0;
  endtask

  // Starts a step and counts cycles to stepDone_o; optionally fires a stray
  // start/config-write pair on cycle injAt of the step.
  task automatic runStep(input logic [3:0] spikes, input int injAt,
                         output int lat, output int nOvr, output int nErr);
    inSpike_i = spikes;
    start_i   = 1'b1;
    tick();
    start_i   = 1'b0;
    inSpike_i = '0;
    lat  = 1;
    nOvr = 0;
    nErr = 0;
    while (!stepDone_o && lat < STEP_BUDGET) begin
      if (lat == injAt) begin
        start_i   = 1'b1;
        cfgWrEn_i = 1'b1;
        cfgSel_i  = 2'd1;
        cfgAddr_i = 4'd0;
        cfgData_i = 16'h1234;
      end
      tick();
      start_i   = 1'b0;
      cfgWrEn_i = 1'b0;
      if (overrun_o) nOvr++;
      if (cfgErr_o)  nErr++;
      lat++;
    end
    chk("step_done_seen", {31'b0, stepDone_o}, 32'd1);
    tick();
    chk("busy_after_step", {31'b0, busy_o}, 32'd0);
  endtask

  task automatic drainOne(input logic [31:0] expPkt);
    spkReady_i = 1'b1;
    chk("pkt_valid", {31'b0, spkValid_o}, 32'd1);
    chk("pkt_data", SpikePacket_o, expPkt);
    tick();
    spkReady_i = 1'b0;
    chk("fifo_empty", {31'b0, spkValid_o}, 32'd0);
  endtask

  initial begin
    int lat, nOvr, nErr, cnt;
    logic [31:0] got[$];
    bit doneSeen;

    tick();
    tick();
    rst_i = 1'b0;
    chk("rst_busy",     {31'b0, busy_o},     32'd0);
    chk("rst_valid",    {31'b0, spkValid_o}, 32'd0);
    chk("rst_done",     {31'b0, stepDone_o}, 32'd0);
    chk("rst_overrun",  {31'b0, overrun_o},  32'd0);
    chk("rst_cfgerr",   {31'b0, cfgErr_o},   32'd0);
    chk("rst_packet",   SpikePacket_o,       32'd0);

    // basic integrate / fire
    cfgWrite(2'd0, 4'h0, 16'h0100);
    cfgWrite(2'd1, 4'h0, 16'h0180);
    cfgWrite(2'd3, 4'h0, 16'h0020);
    for (int i = 1; i < 4; i++) cfgWrite(2'd1, 4'(i << 2), 16'h7FFF);

    runStep(4'b0001, -1, lat, nOvr, nErr);
    chk("s1_latency", lat, 32'd22);
    chk("s1_no_spike", {31'b0, spkValid_o}, 32'd0);
    chk("s1_pot0", u16(dut.potMem[0]), 32'h00F0);

    runStep(4'b0001, -1, lat, nOvr, nErr);
    chk("s2_latency", lat, 32'd22);
    chk("s2_pot0", u16(dut.potMem[0]), 32'h0020);
    drainOne(32'h0000_0100);

    // saturation on neuron 1
    for (int i = 0; i < 4; i++) cfgWrite(2'd0, 4'(4 + i), 16'h7F00);
    runStep(4'b1111, -1, lat, nOvr, nErr);
    chk("sat_latency", lat, 32'd22);
    chk("sat_pot1", u16(dut.potMem[1]), 32'h0000);
    chk("sat_pot0", u16(dut.potMem[0]), 32'h010E);
    drainOne(32'h0000_0101);

    // leak on neuron 2 driven by bias only
    cfgWrite(2'd2, 4'h8, 16'h0100);
    runStep(4'b0000, -1, lat, nOvr, nErr);
    chk("leak1_pot2", u16(dut.potMem[2]), 32'h00F0);
    chk("leak1_pot0", u16(dut.potMem[0]), 32'h00FE);
    runStep(4'b0000, -1, lat, nOvr, nErr);
    chk("leak2_pot2", u16(dut.potMem[2]), 32'h01D1);
    chk("leak2_pot0", u16(dut.potMem[0]), 32'h00EF);
    chk("leak_no_spike", {31'b0, spkValid_o}, 32'd0);

    // backpressure: every neuron fires, FIFO holds two
    for (int i = 0; i < 4; i++) cfgWrite(2'd1, 4'(i << 2), 16'h8000);
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    doneSeen = 1'b0;
    for (int i = 1; i < 30; i++) begin
      tick();
      if (stepDone_o) doneSeen = 1'b1;
    end
    chk("bp_no_done", {31'b0, doneSeen}, 32'd0);
    chk("bp_state", 32'(dut.state), 32'(CMP));
    chk("bp_neuron", 32'(dut.n), 32'd2);
    chk("bp_head", SpikePacket_o, 32'h0000_0100);
    spkReady_i = 1'b1;
    cnt = 0;
    while (cnt < 100 && !(doneSeen && !spkValid_o)) begin
      if (spkValid_o) got.push_back(SpikePacket_o);
      if (stepDone_o) doneSeen = 1'b1;
      tick();
      cnt++;
    end
    spkReady_i = 1'b0;
    chk("bp_finished", {31'b0, doneSeen}, 32'd1);
    chk("bp_count", got.size(), 32'd4);
    for (int i = 0; i < 4; i++)
      chk("bp_pkt", (i < got.size()) ? got[i] : 32'hDEAD_DEAD, 32'h0000_0100 + 32'(i));
    tick();

    // stray start and config write mid-step
    for (int i = 0; i < 4; i++) cfgWrite(2'd1, 4'(i << 2), 16'h7FFF);
    runStep(4'b0000, 5, lat, nOvr, nErr);
    chk("perr_latency", lat, 32'd22);
    chk("perr_overrun", nOvr, 32'd1);
    chk("perr_cfgerr", nErr, 32'd1);
    chk("perr_th0", u16(dut.thMem[0]), 32'h7FFF);

    // reset mid-step with one packet queued
    cfgWrite(2'd1, 4'h0, 16'h8000);
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    for (int i = 1; i < 10; i++) tick();
    chk("rq_queued", {31'b0, spkValid_o}, 32'd1);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    chk("rq_busy", {31'b0, busy_o}, 32'd0);
    chk("rq_valid", {31'b0, spkValid_o}, 32'd0);
    for (int i = 0; i < 4; i++) chk("rq_pot", u16(dut.potMem[i]), 32'h0000);

    cfgWrite(2'd0, 4'h0, 16'h0100);
    cfgWrite(2'd1, 4'h0, 16'h0080);
    cfgWrite(2'd3, 4'h0, 16'h0055);
    for (int i = 1; i < 4; i++) cfgWrite(2'd1, 4'(i << 2), 16'h7FFF);
    runStep(4'b0001, -1, lat, nOvr, nErr);
    chk("post_latency", lat, 32'd22);
    chk("post_pot0", u16(dut.potMem[0]), 32'h0055);
    drainOne(32'h0000_0100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
